// File: rtl/mem_copy_if.sv
// Control and memory-port bundle for mem_copy_engine.
// The engine takes the master view: it receives the copy request and drives
// the memory port. The slave view belongs to whoever issues requests and
// owns the memory.
interface mem_copy_if #(
   parameter int AW = 12,
   parameter int DW = 32
);
   logic          start;
   logic [AW-1:0] src;
   logic [AW-1:0] dst;
   logic [AW:0]   len;
   logic          busy;
   logic          done;
   logic [AW-1:0] mem_address;
   logic          mem_we;
   logic [DW-1:0] mem_datain;
   logic [DW-1:0] mem_dataout;

   modport master (
      input  start, src, dst, len, mem_dataout,
      output busy, done, mem_address, mem_we, mem_datain
   );

   modport slave (
      output start, src, dst, len, mem_dataout,
      input  busy, done, mem_address, mem_we, mem_datain
   );
endinterface

// File: rtl/mem_copy_engine.sv
// Block-copy initiator for a synchronous single-port memory.
// Each word takes one RD cycle and one WR cycle. The data read in RD comes
// back registered during WR and is wired straight to the write data, so the
// engine holds no data path of its own. Copies go in ascending order, which
// gives forward-copy semantics when the regions overlap.
module mem_copy_engine #(
   parameter int AW = 12,
   parameter int DW = 32
) (
   input logic        clk,
   input logic        rst,
   mem_copy_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] src_q, src_d;
   logic [AW-1:0] dst_q, dst_d;
   logic [AW:0]   rem_q, rem_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [DW-1:0] rd_data;

   // Next-state and request-latch logic; busy/done follow the next state so
   // they are registered and line up exactly with the state they describe.
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      rem_d   = rem_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.len != '0) begin
                  src_d   = bus.src;
                  dst_d   = bus.dst;
                  rem_d   = bus.len;
                  state_d = S_RD;
               end else begin
                  // Zero-length request completes without touching memory.
                  state_d = S_DONE;
               end
            end
         end
         S_RD: state_d = S_WR;
         S_WR: begin
            // Addresses wrap naturally at AW bits.
            src_d   = src_q + 1'b1;
            dst_d   = dst_q + 1'b1;
            rem_d   = rem_q - 1'b1;
            state_d = (rem_q == (AW+1)'(1)) ? S_DONE : S_RD;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_RD) || (state_d == S_WR);
      done_d = (state_d == S_DONE);
   end

   // State and latched request; reset drops everything to IDLE at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Memory port decode: purely from registers, so the address only moves at
   // clock edges, and write enable falls the moment reset clears the state.
   always_comb begin
      bus.mem_we      = 1'b0;
      bus.mem_address = '0;
      case (state_q)
         S_RD: bus.mem_address = src_q;
         S_WR: begin
            bus.mem_we      = 1'b1;
            bus.mem_address = dst_q;
         end
         default: ;
      endcase
   end

   assign rd_data        = bus.mem_dataout;
   assign bus.mem_datain = rd_data;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: a behavioural 4096x32 memory, a reference copy
// model feeding expected read/write queues, and one task per scenario.
module tb_mem_copy_engine;

   logic clk = 1'b0;
   logic rst;

   mem_copy_if #(.AW(12), .DW(32)) bus();

   mem_copy_engine #(.AW(12), .DW(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] addr;
      logic [31:0] data;
   } wr_t;

   logic [31:0] mem   [4096];
   logic [31:0] model [4096];
   wr_t         wq [$];
   logic [11:0] rq [$];

   logic        pre_we = 1'b0;
   logic [11:0] pre_addr = '0;
   logic [31:0] pre_data = '0;
   int          n_wr = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   logic        prev_we = 1'b0;

   // Memory: preload port has priority; read data registered every cycle.
   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (bus.mem_we) begin
         mem[bus.mem_address] <= bus.mem_datain;
         n_wr <= n_wr + 1;
      end
      bus.mem_dataout <= mem[bus.mem_address];
   end

   // Bus monitor: pops expected reads/writes as the DUT issues them.
   always @(negedge clk) begin
      if (rst) prev_we = 1'b0;
      else begin
         if (bus.mem_we) begin
            n_chk++;
            if (wq.size() == 0) begin
               n_fail++;
               $display("FAIL wr_unexpected addr %03h data %08h", bus.mem_address, bus.mem_datain);
            end else begin
               wr_t e;
               e = wq.pop_front();
               if (bus.mem_address !== e.addr || bus.mem_datain !== e.data) begin
                  n_fail++;
                  $display("FAIL wr_beat got %03h/%08h exp %03h/%08h",
                           bus.mem_address, bus.mem_datain, e.addr, e.data);
               end
            end
            n_chk++;
            if (prev_we) begin
               n_fail++;
               $display("FAIL we_consecutive got 1 exp 0");
            end
         end else if (bus.busy) begin
            n_chk++;
            if (rq.size() == 0) begin
               n_fail++;
               $display("FAIL rd_unexpected addr %03h", bus.mem_address);
            end else begin
               logic [11:0] ea;
               ea = rq.pop_front();
               if (bus.mem_address !== ea) begin
                  n_fail++;
                  $display("FAIL rd_addr got %03h exp %03h", bus.mem_address, ea);
               end
            end
         end
         prev_we = bus.mem_we;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic preload(input logic [11:0] a, input logic [31:0] v);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = a; pre_data = v;
      @(posedge clk);
      #1 pre_we = 1'b0;
      model[a] = v;
   endtask

   task automatic check_region(input string tag, input logic [11:0] d, input int n);
      for (int i = 0; i < n; i++) begin
         logic [11:0] a;
         a = d + 12'(i);
         n_chk++;
         if (mem[a] !== model[a]) begin
            n_fail++;
            $display("FAIL %s mem[%03h] got %08h exp %08h", tag, a, mem[a], model[a]);
         end
      end
   endtask

   // One copy: push expectations, pulse start, then follow busy/done until
   // the done cycle. inject pulses start once while busy and once in DONE.
   task automatic run_copy(input string tag, input logic [11:0] s, input logic [11:0] d,
                           input int n, input bit inject);
      int busy_cnt, done_cnt, done_cyc;
      bit we_seen;
      for (int i = 0; i < n; i++) begin
         logic [11:0] sa, da;
         sa = s + 12'(i);
         da = d + 12'(i);
         rq.push_back(sa);
         wq.push_back('{addr: da, data: model[sa]});
         model[da] = model[sa];
      end
      @(negedge clk);
      bus.start = 1'b1; bus.src = s; bus.dst = d; bus.len = 13'(n);
      @(posedge clk);
      #1 bus.start = 1'b0;
      busy_cnt = 0; done_cnt = 0; done_cyc = 0; we_seen = 1'b0;
      for (int k = 1; k <= 2*n + 1; k++) begin
         @(negedge clk);
         if (bus.busy) busy_cnt++;
         if (bus.done) begin done_cnt++; done_cyc = k; end
         if (bus.mem_we) we_seen = 1'b1;
         if (inject && (k == 3 || k == 2*n + 1)) begin
            bus.start = 1'b1;
            bus.src = 12'h5A5; bus.dst = 12'hA5A;
            bus.len = (k == 3) ? 13'd2 : 13'd0;
         end else bus.start = 1'b0;
      end
      if (inject) begin
         @(negedge clk);
         bus.start = 1'b0;
         n_chk++;
         if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start_in_done busy/done got %b/%b exp 0/0", tag, bus.busy, bus.done);
         end
      end
      n_chk++;
      if (busy_cnt != 2*n) begin
         n_fail++;
         $display("FAIL %s busy_cycles got %0d exp %0d", tag, busy_cnt, 2*n);
      end
      n_chk++;
      if (done_cnt != 1 || done_cyc != 2*n + 1) begin
         n_fail++;
         $display("FAIL %s done got %0d pulses at cycle %0d exp 1 at %0d", tag, done_cnt, done_cyc, 2*n+1);
      end
      n_chk++;
      if (wq.size() != 0 || rq.size() != 0) begin
         n_fail++;
         $display("FAIL %s pending got %0d wr %0d rd exp 0", tag, wq.size(), rq.size());
      end
      if (n == 0) begin
         n_chk++;
         if (we_seen) begin
            n_fail++;
            $display("FAIL %s len0_we got 1 exp 0", tag);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0; bus.src = '0; bus.dst = '0; bus.len = '0;
      repeat (2) @(negedge clk);
      n_chk++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_address !== 12'h0) begin
         n_fail++;
         $display("FAIL reset_state got busy %b done %b we %b addr %03h exp 0",
                  bus.busy, bus.done, bus.mem_we, bus.mem_address);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [31:0] a [4];
      a = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hA333_3333};
      for (int i = 0; i < 4; i++) preload(12'h010 + 12'(i), a[i]);
      for (int i = 0; i < 4; i++) preload(12'h100 + 12'(i), 32'h0);
      run_copy("basic", 12'h010, 12'h100, 4, 1'b0);
      check_region("basic_dst", 12'h100, 4);
      for (int i = 0; i < 4; i++) begin
         n_chk++;
         if (mem[12'h010 + 12'(i)] !== a[i] || mem[12'h100 + 12'(i)] !== a[i]) begin
            n_fail++;
            $display("FAIL basic_word%0d got src %08h dst %08h exp %08h", i,
                     mem[12'h010 + 12'(i)], mem[12'h100 + 12'(i)], a[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      // Second start lands in the cycle right after the first done.
      preload(12'h040, 32'hB0B0_0001);
      preload(12'h041, 32'hB0B0_0002);
      run_copy("b2b_1", 12'h040, 12'h140, 1, 1'b0);
      run_copy("b2b_2", 12'h041, 12'h141, 1, 1'b0);
      check_region("b2b_dst", 12'h140, 2);
   endtask

   task automatic test_wrap();
      preload(12'hFFE, 32'hC0DE_0FFE);
      preload(12'hFFF, 32'hC0DE_0FFF);
      preload(12'h000, 32'hC0DE_0000);
      run_copy("wrap", 12'hFFE, 12'h7FF, 3, 1'b0);
      check_region("wrap_dst", 12'h7FF, 3);
      n_chk++;
      if (mem[12'h801] !== 32'hC0DE_0000) begin
         n_fail++;
         $display("FAIL wrap_last got %08h exp %08h", mem[12'h801], 32'hC0DE_0000);
      end
   endtask

   task automatic test_overlap();
      preload(12'h020, 32'h55);
      for (int i = 1; i < 4; i++) preload(12'h020 + 12'(i), 32'h0);
      run_copy("overlap", 12'h020, 12'h021, 3, 1'b0);
      for (int i = 1; i < 4; i++) begin
         n_chk++;
         if (mem[12'h020 + 12'(i)] !== 32'h55) begin
            n_fail++;
            $display("FAIL overlap mem[%03h] got %08h exp 00000055", 12'h020 + 12'(i), mem[12'h020 + 12'(i)]);
         end
      end
   endtask

   task automatic test_len0();
      int w0;
      w0 = n_wr;
      run_copy("len0", 12'h123, 12'h456, 0, 1'b0);
      n_chk++;
      if (n_wr != w0) begin
         n_fail++;
         $display("FAIL len0_writes got %0d exp 0", n_wr - w0);
      end
   endtask

   task automatic test_ignore_start();
      preload(12'h060, 32'hD00D_0060);
      preload(12'h061, 32'hD00D_0061);
      preload(12'h062, 32'hD00D_0062);
      run_copy("ignore", 12'h060, 12'h160, 3, 1'b1);
      check_region("ignore_dst", 12'h160, 3);
   endtask

   task automatic test_reset_mid_copy();
      int w0, written;
      logic [31:0] old [5];
      for (int i = 0; i < 5; i++) begin
         preload(12'h200 + 12'(i), 32'hE000_0200 + 32'(i));
         old[i] = 32'hDEAD_0000 + 32'(i);
         preload(12'h300 + 12'(i), old[i]);
      end
      for (int i = 0; i < 5; i++) begin
         rq.push_back(12'h200 + 12'(i));
         wq.push_back('{addr: 12'h300 + 12'(i), data: model[12'h200 + 12'(i)]});
      end
      w0 = n_wr;
      @(negedge clk);
      bus.start = 1'b1; bus.src = 12'h200; bus.dst = 12'h300; bus.len = 13'd5;
      @(posedge clk);
      #1 bus.start = 1'b0;
      // Cycle 6 is the WR of the third word.
      repeat (6) @(negedge clk);
      n_chk++;
      if (bus.mem_we !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_pre_we got %b exp 1", bus.mem_we);
      end
      #2 rst = 1'b1;
      #1;
      n_chk++;
      if (bus.mem_we !== 1'b0 || bus.busy !== 1'b0 || bus.mem_address !== 12'h0) begin
         n_fail++;
         $display("FAIL rstmid_async got we %b busy %b addr %03h exp 0/0/000",
                  bus.mem_we, bus.busy, bus.mem_address);
      end
      wq.delete();
      rq.delete();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k == 2) rst = 1'b0;
         n_chk++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_quiet got done %b busy %b exp 0/0", bus.done, bus.busy);
         end
      end
      written = n_wr - w0;
      n_chk++;
      if (written < 1 || written > 2) begin
         n_fail++;
         $display("FAIL rstmid_written got %0d exp 1..2", written);
      end
      for (int i = 0; i < 5; i++) begin
         logic [31:0] e;
         e = (i < written) ? 32'hE000_0200 + 32'(i) : old[i];
         model[12'h300 + 12'(i)] = e;
      end
      check_region("rstmid_dst", 12'h300, 5);
      preload(12'h210, 32'hF00D_0210);
      run_copy("post_rst", 12'h210, 12'h310, 1, 1'b0);
      check_region("post_rst_dst", 12'h310, 1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_wrap();
      test_overlap();
      test_len0();
      test_ignore_start();
      test_reset_mid_copy();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
